pwm_multichannel_peripheral: RTL and testbench

//  Generalised register-mapped PWM engine: NUM_CH channels, CNT_W-bit counter, per-channel duty,

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_timebase.sv | 79 +++++++
 rtl/pwm_multichannel_peripheral.sv | 98 +++++++++
 tb/tb_pwm_multichannel_peripheral.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multichannel PWM peripheral.
//   - register address map (write-only register file)
//   - counting mode and counter direction encodings
//   - bank_addr(): address of bank/channel idx within a register block
package pwm_pkg;

  localparam logic [6:0] ADDR_EN_OUT   = 7'h00;
  localparam logic [6:0] ADDR_EN_PWM   = 7'h04;
  localparam logic [6:0] ADDR_PRESCALE = 7'h08;
  localparam logic [6:0] ADDR_CTRL     = 7'h09;
  localparam logic [6:0] ADDR_DUTY     = 7'h20;

  localparam int unsigned BANK_W = 8;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTRE = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic logic [6:0] bank_addr(input logic [6:0] base, input int unsigned idx);
    return base + 7'(idx);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler and PWM counter.
//   clk, rst     : system clock, synchronous active-high reset
//   prescale     : tick every prescale+1 clocks
//   prescale_wr  : PRESCALE register write this clock (restarts the prescaler)
//   mode         : active counting mode (edge: saw-tooth, centre: triangle)
//   cnt          : current counter value
//   boundary     : high on the tick where a new period starts (counter becomes 0)
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PRE_W-1:0] prescale,
  input  logic             prescale_wr,
  input  mode_e            mode,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  dir_e             dir, dir_next;
  logic [CNT_W-1:0] cnt_next;

  assign tick = (pre_cnt == prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (prescale_wr || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Centre mode: every boundary restarts at 0 in DIR_DOWN so that the next
  // tick holds 0 once more before turning up; this gives the sequence
  // 0,0,1..MAX,MAX..1 (2^(CNT_W+1) ticks) with the period starting at the
  // down-count reaching 0. In edge mode dir is ignored.
  always_comb begin
    boundary = 1'b0;
    cnt_next = cnt;
    dir_next = dir;
    if (tick) begin
      if (mode == MODE_EDGE) begin
        boundary = (cnt == '1);
      end else begin
        boundary = (dir == DIR_DOWN) && (cnt == CNT_W'(1));
      end
      if (boundary) begin
        cnt_next = '0;
        dir_next = DIR_DOWN;
      end else if (mode == MODE_EDGE) begin
        cnt_next = cnt + CNT_W'(1);
      end else if (dir == DIR_UP) begin
        if (cnt == '1) dir_next = DIR_DOWN;
        else           cnt_next = cnt + CNT_W'(1);
      end else begin
        if (cnt == '0) dir_next = DIR_UP;
        else            cnt_next = cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else begin
      cnt <= cnt_next;
      dir <= dir_next;
    end
  end

endmodule

// File: rtl/pwm_multichannel_peripheral.sv
// Register-mapped multichannel PWM engine.
//   clk, rst     : system clock, synchronous active-high reset
//   wr_valid     : one-cycle register write strobe
//   wr_addr      : register address (7 bits)
//   wr_data      : write data, LSB-aligned
//   out          : registered channel outputs, NUM_CH bits
//   period_start : one-clock pulse in the clock where the counter restarts
// Duty and mode writes land in shadow registers and are committed together
// at the period boundary; enables and prescale act immediately.
module pwm_multichannel_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PRE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [6:0]        wr_addr,
  input  logic [15:0]       wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam int unsigned NUM_BANKS = NUM_CH / BANK_W;

  logic [NUM_CH-1:0] en_out, en_pwm, pwm;
  logic [CNT_W-1:0]  duty_sh [NUM_CH];
  logic [CNT_W-1:0]  duty    [NUM_CH];
  logic [PRE_W-1:0]  prescale;
  mode_e             mode, mode_sh;
  logic              prescale_wr, boundary;
  logic [CNT_W-1:0]  cnt;
  logic              unused_wr_bits;

  // Upper data bits beyond each register's width are ignored by design.
  assign unused_wr_bits = ^wr_data;
  assign prescale_wr    = wr_valid && (wr_addr == ADDR_PRESCALE);

  pwm_timebase #(
    .CNT_W(CNT_W),
    .PRE_W(PRE_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .prescale    (prescale),
    .prescale_wr (prescale_wr),
    .mode        (mode),
    .cnt         (cnt),
    .boundary    (boundary)
  );

  // Commit reads the shadow before this clock's write updates it, so a write
  // on the boundary clock only takes effect one period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out       <= '0;
      en_pwm       <= '0;
      prescale     <= '0;
      mode         <= MODE_EDGE;
      mode_sh      <= MODE_EDGE;
      period_start <= 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        duty_sh[k] <= '0;
        duty[k]    <= '0;
      end
    end else begin
      period_start <= boundary;
      if (boundary) begin
        mode <= mode_sh;
        for (int unsigned k = 0; k < NUM_CH; k++) duty[k] <= duty_sh[k];
      end
      if (wr_valid) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          if (wr_addr == bank_addr(ADDR_EN_OUT, b)) en_out[BANK_W*b +: BANK_W] <= wr_data[BANK_W-1:0];
          if (wr_addr == bank_addr(ADDR_EN_PWM, b)) en_pwm[BANK_W*b +: BANK_W] <= wr_data[BANK_W-1:0];
        end
        if (prescale_wr)            prescale <= wr_data[PRE_W-1:0];
        if (wr_addr == ADDR_CTRL)   mode_sh  <= mode_e'(wr_data[0]);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (wr_addr == bank_addr(ADDR_DUTY, k)) duty_sh[k] <= wr_data[CNT_W-1:0];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cmp
    assign pwm[k] = (duty[k] == '1) ? 1'b1 : (cnt < duty[k]);
  end

  // Enabled channel: PWM waveform, or static high when PWM is disabled.
  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= en_out & (~en_pwm | pwm);
  end

endmodule

// File: tb/tb_pwm_multichannel_peripheral.sv
module tb_pwm_multichannel_peripheral;

  localparam int NCH  = 16;
  localparam int MAXV = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [6:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] out;
  logic        period_start;

  int total = 0;
  int bad   = 0;
  int prints = 0;
  bit chk_en = 1'b0;

  pwm_multichannel_peripheral #(
    .NUM_CH(16),
    .CNT_W (8),
    .PRE_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .out          (out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Position p within the current period (in ticks); counter value derived
  // arithmetically from p and the active mode.
  int          m_sh [NCH];
  int          m_duty [NCH];
  logic [15:0] m_en_out = '0, m_en_pwm = '0, m_out = '0;
  int          m_pre = 0, m_precnt = 0, m_p = 0;
  bit          m_mode = 0, m_mode_sh = 0, m_ps = 0;

  function automatic int m_cnt();
    if (!m_mode) return m_p;
    if (m_p == 0) return 0;
    if (m_p <= MAXV + 1) return m_p - 1;
    return 2 * (MAXV + 1) - m_p;
  endfunction

  int          mc, mnp, ma;
  bit          mtick, mbnd;
  logic [15:0] mnout;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin m_sh[k] = 0; m_duty[k] = 0; end
      m_en_out = '0; m_en_pwm = '0; m_out = '0;
      m_pre = 0; m_precnt = 0; m_p = 0;
      m_mode = 0; m_mode_sh = 0; m_ps = 0;
    end else begin
      mc = m_cnt();
      for (int k = 0; k < NCH; k++)
        mnout[k] = !m_en_out[k] ? 1'b0 : !m_en_pwm[k] ? 1'b1 :
                   ((m_duty[k] == MAXV) || (mc < m_duty[k]));
      mtick = (m_precnt == m_pre);
      mbnd  = 0;
      if (mtick) begin
        mnp = m_p + 1;
        if (mnp == (m_mode ? 2 * (MAXV + 1) : MAXV + 1)) begin mnp = 0; mbnd = 1; end
        m_p = mnp;
      end
      if (mbnd) begin
        for (int k = 0; k < NCH; k++) m_duty[k] = m_sh[k];
        m_mode = m_mode_sh;
      end
      if (mtick || (wr_valid && wr_addr == 7'h08)) m_precnt = 0;
      else m_precnt = m_precnt + 1;
      m_ps  = mbnd;
      m_out = mnout;
      if (wr_valid) begin
        ma = int'(wr_addr);
        if (ma < NCH / 8)                       m_en_out[ma*8 +: 8] = wr_data[7:0];
        else if (ma >= 4 && ma < 4 + NCH / 8)   m_en_pwm[(ma-4)*8 +: 8] = wr_data[7:0];
        else if (ma == 8)                       m_pre = int'(wr_data[7:0]);
        else if (ma == 9)                       m_mode_sh = wr_data[0];
        else if (ma >= 32 && ma < 32 + NCH)     m_sh[ma-32] = int'(wr_data[7:0]);
      end
    end
  end

  // Scoreboard: every clock, outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (out !== m_out) begin
        bad++;
        if (prints < 20) begin prints++; $display("FAIL model_out t=%0t got=%h exp=%h", $time, out, m_out); end
      end
      total++;
      if (period_start !== m_ps) begin
        bad++;
        if (prints < 20) begin prints++; $display("FAIL model_period_start t=%0t got=%b exp=%b", $time, period_start, m_ps); end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic wait_ps(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      cyc();
      if (period_start === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic measure(input int n, input int ch, output int highs, output int pss, output bit last_ps);
    highs = 0; pss = 0; last_ps = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (out[ch] === 1'b1) highs++;
      if (period_start === 1'b1) pss++;
      last_ps = (period_start === 1'b1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [6:0]  ra [3] = '{7'h00, 7'h04, 7'h20};
    logic [15:0] rd [3] = '{16'h00FF, 16'h0000, 16'h0080};
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = ra[i]; wr_data = rd[i];
      cyc();
      chk_en = 1'b1;
      total++;
      if (out !== 16'h0 || period_start !== 1'b0) begin
        bad++; $display("FAIL reset_state cyc=%0d got out=%h ps=%b exp out=0000 ps=0", i, out, period_start);
      end
    end
    wr_valid = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (out !== 16'h0 || period_start !== 1'b0) begin
        bad++; $display("FAIL reset_writes_ignored cyc=%0d got out=%h ps=%b exp out=0000 ps=0", i, out, period_start);
      end
    end
  endtask

  task automatic test_edge_duty();
    int h, p; bit l, ok;
    wr(7'h00, 16'h0001);
    wr(7'h04, 16'h0001);
    wr(7'h20, 16'd64);
    wait_ps(600, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL edge_wait_ps got=timeout exp=pulse"); end
    measure(256, 0, h, p, l);
    total++;
    if (h != 64) begin bad++; $display("FAIL edge_duty64 got=%0d exp=64", h); end
    total++;
    if (!l || p != 1) begin bad++; $display("FAIL edge_period256 got last=%0d count=%0d exp last=1 count=1", l, p); end
  endtask

  task automatic test_duty_extremes();
    int h, p; bit l, ok;
    int dv [2] = '{0, 255};
    int ex [2] = '{0, 256};
    for (int i = 0; i < 2; i++) begin
      wr(7'h20, 16'(dv[i]));
      wait_ps(600, ok);
      measure(256, 0, h, p, l);
      total++;
      if (!ok || h != ex[i]) begin bad++; $display("FAIL duty_extreme duty=%0d got=%0d exp=%0d ok=%0d", dv[i], h, ex[i], ok); end
    end
    wr(7'h20, 16'd0);
    wait_ps(600, ok);
    wr(7'h04, 16'h0000);
    measure(256, 0, h, p, l);
    total++;
    if (h != 256) begin bad++; $display("FAIL en_pwm_off_const_high got=%0d exp=256", h); end
    wr(7'h04, 16'h0001);
  endtask

  task automatic test_shadowing();
    int h, p; bit l, ok;
    wr(7'h20, 16'd128);
    wait_ps(600, ok);
    h = 0; l = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 100) begin wr_valid = 1'b1; wr_addr = 7'h20; wr_data = 16'd32; end
      cyc();
      wr_valid = 1'b0;
      if (out[0] === 1'b1) h++;
      l = (period_start === 1'b1);
    end
    total++;
    if (!ok || h != 128) begin bad++; $display("FAIL shadow_this_period got=%0d exp=128", h); end
    total++;
    if (!l) begin bad++; $display("FAIL shadow_period_start got=0 exp=1"); end
    measure(256, 0, h, p, l);
    total++;
    if (h != 32) begin bad++; $display("FAIL shadow_next_period got=%0d exp=32", h); end
  endtask

  task automatic test_boundary_write();
    int h, p, oldd, newd; bit l, ok;
    oldd = $urandom_range(1, 254);
    newd = $urandom_range(1, 254);
    if (newd == oldd) newd = (oldd == 1) ? 2 : 1;
    wr(7'h20, 16'(oldd));
    wait_ps(600, ok);
    h = 0; l = 0;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin wr_valid = 1'b1; wr_addr = 7'h20; wr_data = 16'(newd); end
      cyc();
      wr_valid = 1'b0;
      if (out[0] === 1'b1) h++;
      l = (period_start === 1'b1);
    end
    total++;
    if (!ok || !l || h != oldd) begin bad++; $display("FAIL bwrite_setup got=%0d ps=%0d exp=%0d ps=1", h, l, oldd); end
    measure(256, 0, h, p, l);
    total++;
    if (h != oldd) begin bad++; $display("FAIL bwrite_old_committed got=%0d exp=%0d", h, oldd); end
    measure(256, 0, h, p, l);
    total++;
    if (h != newd) begin bad++; $display("FAIL bwrite_new_next got=%0d exp=%0d", h, newd); end
  endtask

  task automatic test_centre();
    int h, p; bit l, ok, mid, edge_hi;
    wr(7'h20, 16'd64);
    wr(7'h08, 16'd3);
    wr(7'h09, 16'h0001);
    wr(7'h00, 16'h0003);
    wr(7'h04, 16'h0003);
    wr(7'h21, 16'd100);
    wait_ps(1500, ok);
    h = 0; p = 0; l = 0; mid = 1'bx;
    for (int i = 0; i < 2048; i++) begin
      cyc();
      if (out[1] === 1'b1) h++;
      if (period_start === 1'b1) p++;
      if (i == 1023) mid = out[1];
      l = (period_start === 1'b1);
      edge_hi = out[1];
    end
    total++;
    if (!ok || h != 800) begin bad++; $display("FAIL centre_high got=%0d exp=800", h); end
    total++;
    if (!l || p != 1) begin bad++; $display("FAIL centre_period2048 got last=%0d count=%0d exp last=1 count=1", l, p); end
    total++;
    if (mid !== 1'b0 || edge_hi !== 1'b1) begin
      bad++; $display("FAIL centre_alignment got mid=%b at_ps=%b exp mid=0 at_ps=1", mid, edge_hi);
    end
  endtask

  task automatic test_unmapped();
    int h0, h1, hx; bit ok;
    wr(7'h1F, 16'($urandom));
    wr(7'h30, 16'($urandom));
    wr(7'h02, 16'hFFFF);
    wr(7'h06, 16'hFFFF);
    wr(7'h0A, 16'hFFFF);
    wait_ps(2100, ok);
    h0 = 0; h1 = 0; hx = 0;
    for (int i = 0; i < 2048; i++) begin
      cyc();
      if (out[0] === 1'b1) h0++;
      if (out[1] === 1'b1) h1++;
      if (out[15:2] !== 14'h0) hx++;
    end
    total++;
    if (!ok || h0 != 512 || h1 != 800) begin
      bad++; $display("FAIL unmapped_no_effect got ch0=%0d ch1=%0d exp ch0=512 ch1=800", h0, h1);
    end
    total++;
    if (hx != 0) begin bad++; $display("FAIL unmapped_other_channels got=%0d exp=0", hx); end
  endtask

  task automatic test_random();
    int r, n;
    logic [6:0] a;
    logic [15:0] d;
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1;
        wr_valid = 1'b1; wr_addr = 7'h00; wr_data = 16'($urandom);
        cyc();
        rst = 1'b0; wr_valid = 1'b0;
      end else if (r < 45) begin
        case ($urandom_range(0, 6))
          0: a = 7'(($urandom_range(0, 1)));
          1: a = 7'(4 + $urandom_range(0, 1));
          2: a = 7'h08;
          3: a = 7'h09;
          4, 5: a = 7'(32 + $urandom_range(0, NCH - 1));
          default: a = 7'($urandom_range(0, 127));
        endcase
        d = 16'($urandom);
        if (a == 7'h08) d = 16'($urandom_range(0, 3));
        wr(a, d);
      end else begin
        n = $urandom_range(1, 60);
        repeat (n) cyc();
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge_duty();
    test_duty_extremes();
    test_shadowing();
    test_boundary_write();
    test_centre();
    test_unmapped();
    test_random();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
